// File: rtl/fwu_frame_rx_if.sv
// Byte-stream, command and payload signals of the firmware-update receive framer.
// slave is the framer side; master is the SLIP decoder / command handler side.
interface fwu_frame_rx_if;
   logic        slip_start;
   logic        slip_end;
   logic [7:0]  slip_data;
   logic        slip_valid;
   logic        slip_ready;
   logic        cmd_valid;
   logic [7:0]  cmd_type;
   logic [15:0] cmd_seq;
   logic [15:0] cmd_len;
   logic [7:0]  pay_data;
   logic        pay_valid;
   logic        pay_ready;
   logic        pay_last;
   logic        frm_done;
   logic [2:0]  frm_err;
   logic [15:0] err_cnt;

   modport slave (
      input  slip_start, slip_end, slip_data, slip_valid, pay_ready,
      output slip_ready, cmd_valid, cmd_type, cmd_seq, cmd_len,
             pay_data, pay_valid, pay_last, frm_done, frm_err, err_cnt
   );

   modport master (
      output slip_start, slip_end, slip_data, slip_valid, pay_ready,
      input  slip_ready, cmd_valid, cmd_type, cmd_seq, cmd_len,
             pay_data, pay_valid, pay_last, frm_done, frm_err, err_cnt
   );
endinterface

// File: rtl/fwu_frame_rx.sv
// Receive framer: checks 55 AA 01 header, len limit and CRC32, streams payload
// unbuffered and reports one verdict per frame.
`ifndef FWU_MAX_PAYLOAD
`define FWU_MAX_PAYLOAD 1024
`endif

module fwu_frame_rx #(
   parameter int unsigned MAX_PAYLOAD = `FWU_MAX_PAYLOAD
) (
   input logic             clk,
   input logic             rst_n,
   fwu_frame_rx_if.slave   bus
);

   typedef enum logic [2:0] {StIdle, StHdr, StPay, StCrc, StWaitEnd, StDrop} state_e;

   localparam logic [2:0] ErrNone  = 3'd0;
   localparam logic [2:0] ErrMagic = 3'd1;
   localparam logic [2:0] ErrVer   = 3'd2;
   localparam logic [2:0] ErrLen   = 3'd3;
   localparam logic [2:0] ErrCrc   = 3'd4;
   localparam logic [2:0] ErrShort = 3'd5;
   localparam logic [2:0] ErrLong  = 3'd6;

   // Reflected IEEE CRC-32, one byte per call.
   function automatic logic [31:0] crc32_ieee(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] r;
      r = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [31:0] rx_crc_q, rx_crc_d;
   logic [2:0]  err_lat_q, err_lat_d;
   logic [7:0]  type_q, type_d;
   logic [15:0] seq_q, seq_d;
   logic [15:0] len_q, len_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        done_q, done_d;
   logic [2:0]  frm_err_q, frm_err_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [2:0]  verdict;
   logic [15:0] len_new;
   logic        accept;

   assign bus.slip_ready = (state_q == StPay) ? bus.pay_ready : 1'b1;
   assign accept         = bus.slip_valid && bus.slip_ready;
   assign bus.pay_valid  = (state_q == StPay) && bus.slip_valid;
   assign bus.pay_data   = (state_q == StPay) ? bus.slip_data : 8'd0;
   assign bus.pay_last   = (state_q == StPay) && (cnt_q == len_q - 16'd1);
   assign bus.cmd_valid  = cmd_valid_q;
   assign bus.cmd_type   = type_q;
   assign bus.cmd_seq    = seq_q;
   assign bus.cmd_len    = len_q;
   assign bus.frm_done   = done_q;
   assign bus.frm_err    = frm_err_q;
   assign bus.err_cnt    = err_cnt_q;
   assign len_new        = {len_q[15:8], bus.slip_data};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      crc_d       = crc_q;
      rx_crc_d    = rx_crc_q;
      err_lat_d   = err_lat_q;
      type_d      = type_q;
      seq_d       = seq_q;
      len_d       = len_q;
      cmd_valid_d = 1'b0;
      done_d      = 1'b0;
      verdict     = ErrNone;

      if (bus.slip_start) begin
         // A restart before the verdict closes the old frame as truncated.
         if (state_q != StIdle) begin
            done_d  = 1'b1;
            verdict = ErrShort;
         end
         state_d   = StHdr;
         idx_d     = 3'd0;
         cnt_d     = 16'd0;
         crc_d     = '1;
         err_lat_d = ErrNone;
      end else if (bus.slip_end) begin
         unique case (state_q)
            StHdr, StPay, StCrc: begin
               done_d  = 1'b1;
               verdict = ErrShort;
               state_d = StIdle;
            end
            StWaitEnd: begin
               done_d  = 1'b1;
               verdict = (rx_crc_q == ~crc_q) ? ErrNone : ErrCrc;
               state_d = StIdle;
            end
            StDrop: begin
               done_d  = 1'b1;
               verdict = err_lat_q;
               state_d = StIdle;
            end
            default: ;
         endcase
      end else if (accept) begin
         unique case (state_q)
            StHdr: begin
               crc_d = crc32_ieee(crc_q, bus.slip_data);
               idx_d = idx_q + 3'd1;
               case (idx_q)
                  3'd0: if (bus.slip_data != 8'h55) begin
                     err_lat_d = ErrMagic;
                     state_d   = StDrop;
                  end
                  3'd1: if (bus.slip_data != 8'hAA) begin
                     err_lat_d = ErrMagic;
                     state_d   = StDrop;
                  end
                  3'd2: if (bus.slip_data != 8'h01) begin
                     err_lat_d = ErrVer;
                     state_d   = StDrop;
                  end
                  3'd3: type_d = bus.slip_data;
                  3'd4: seq_d  = {bus.slip_data, seq_q[7:0]};
                  3'd5: seq_d  = {seq_q[15:8], bus.slip_data};
                  3'd6: len_d  = {bus.slip_data, len_q[7:0]};
                  default: begin
                     len_d = len_new;
                     idx_d = 3'd0;
                     if ({16'd0, len_new} > MAX_PAYLOAD) begin
                        err_lat_d = ErrLen;
                        state_d   = StDrop;
                     end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = (len_new != 16'd0) ? StPay : StCrc;
                     end
                  end
               endcase
            end
            StPay: begin
               crc_d = crc32_ieee(crc_q, bus.slip_data);
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == len_q - 16'd1) begin
                  state_d = StCrc;
                  idx_d   = 3'd0;
               end
            end
            StCrc: begin
               rx_crc_d = {rx_crc_q[23:0], bus.slip_data};
               idx_d    = idx_q + 3'd1;
               if (idx_q == 3'd3) state_d = StWaitEnd;
            end
            StWaitEnd: begin
               err_lat_d = ErrLong;
               state_d   = StDrop;
            end
            default: ;
         endcase
      end

      frm_err_d = done_d ? verdict : frm_err_q;
      err_cnt_d = err_cnt_q;
      if (done_d && (verdict != ErrNone) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= 3'd0;
         cnt_q       <= 16'd0;
         crc_q       <= '1;
         rx_crc_q    <= 32'd0;
         err_lat_q   <= ErrNone;
         type_q      <= 8'd0;
         seq_q       <= 16'd0;
         len_q       <= 16'd0;
         cmd_valid_q <= 1'b0;
         done_q      <= 1'b0;
         frm_err_q   <= ErrNone;
         err_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         crc_q       <= crc_d;
         rx_crc_q    <= rx_crc_d;
         err_lat_q   <= err_lat_d;
         type_q      <= type_d;
         seq_q       <= seq_d;
         len_q       <= len_d;
         cmd_valid_q <= cmd_valid_d;
         done_q      <= done_d;
         frm_err_q   <= frm_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_fwu_frame_rx.sv
// Scoreboard bench for fwu_frame_rx: directed frames push expected command, payload
// and verdict entries; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fwu_frame_rx;

   localparam int unsigned MaxPay = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fwu_frame_rx_if bus();

   fwu_frame_rx #(.MAX_PAYLOAD(MaxPay)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;
   logic [31:0] mc;
   logic [39:0] exp_cmd_q[$];
   logic [8:0]  exp_pay_q[$];
   logic [18:0] exp_done_q[$];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name, input logic [39:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h want nothing", name, act);
   endtask

   // Bitwise LSB-first CRC-32 reference (feedback per input bit).
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else r = r >> 1;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.cmd_valid) begin
            if (exp_cmd_q.size() == 0) unexpected("cmd_unexpected", {bus.cmd_type, bus.cmd_seq, bus.cmd_len});
            else check("cmd", {bus.cmd_type, bus.cmd_seq, bus.cmd_len}, exp_cmd_q.pop_front());
         end
         if (bus.pay_valid && bus.pay_ready) begin
            if (exp_pay_q.size() == 0) unexpected("pay_unexpected", {31'd0, bus.pay_data, bus.pay_last});
            else check("pay", {31'd0, bus.pay_data, bus.pay_last}, {31'd0, exp_pay_q.pop_front()});
         end
         if (bus.frm_done) begin
            if (exp_done_q.size() == 0) unexpected("done_unexpected", {21'd0, bus.frm_err, bus.err_cnt});
            else check("verdict", {21'd0, bus.frm_err, bus.err_cnt}, {21'd0, exp_done_q.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tx(input logic [7:0] b, input int stall);
      bit ok = 1'b0;
      bus.slip_data  = b;
      bus.slip_valid = 1'b1;
      if (stall > 0) begin
         bus.pay_ready = 1'b0;
         repeat (stall) begin
            @(negedge clk);
            check("stall_ready", {39'd0, bus.slip_ready}, 40'd0);
            tick();
         end
         bus.pay_ready = 1'b1;
      end
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.slip_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      if (!ok) unexpected("byte_not_accepted", {32'd0, b});
      bus.slip_valid = 1'b0;
      mc = crc_step(mc, b);
   endtask

   task automatic strobe_start();
      bus.slip_start = 1'b1;
      tick();
      bus.slip_start = 1'b0;
      mc = 32'hFFFF_FFFF;
   endtask

   task automatic strobe_end();
      bus.slip_end = 1'b1;
      tick();
      bus.slip_end = 1'b0;
   endtask

   task automatic push_done(input logic [2:0] err);
      if (err != 3'd0 && exp_cnt != 65535) exp_cnt++;
      exp_done_q.push_back({err, 16'(exp_cnt)});
   endtask

   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b2, input logic [7:0] typ,
                            input logic [15:0] seq, input logic [15:0] len, input int npay,
                            input int stall_at, input bit send_crc, input bit flip,
                            input bit extra, input bit no_end, input logic [2:0] exp_err,
                            input bit exp_cmd);
      logic [31:0] c;
      strobe_start();
      if (exp_cmd) exp_cmd_q.push_back({typ, seq, len});
      tx(b0, 0); tx(8'hAA, 0); tx(b2, 0); tx(typ, 0);
      tx(seq[15:8], 0); tx(seq[7:0], 0); tx(len[15:8], 0); tx(len[7:0], 0);
      for (int i = 0; i < npay; i++) begin
         exp_pay_q.push_back({8'(16 * (i + 1)), (i == int'(len) - 1)});
         tx(8'(16 * (i + 1)), (i == stall_at) ? 5 : 0);
      end
      if (send_crc) begin
         c = ~mc ^ {31'd0, flip};
         tx(c[31:24], 0); tx(c[23:16], 0); tx(c[15:8], 0); tx(c[7:0], 0);
      end
      if (extra) tx(8'h00, 0);
      push_done(exp_err);
      if (!no_end) strobe_end();
      repeat (3) tick();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_cmd_valid"}, {39'd0, bus.cmd_valid}, 40'd0);
      check({tag, "_pay_valid"}, {39'd0, bus.pay_valid}, 40'd0);
      check({tag, "_frm_done"}, {39'd0, bus.frm_done}, 40'd0);
      check({tag, "_frm_err"}, {37'd0, bus.frm_err}, 40'd0);
      check({tag, "_err_cnt"}, {24'd0, bus.err_cnt}, 40'd0);
      check({tag, "_cmd_fields"}, {bus.cmd_type, bus.cmd_seq, bus.cmd_len}, 40'd0);
   endtask

   initial begin
      bus.slip_start = 1'b0;
      bus.slip_end   = 1'b0;
      bus.slip_data  = 8'd0;
      bus.slip_valid = 1'b0;
      bus.pay_ready  = 1'b1;
      mc = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      //        b0     b2     typ    seq       len    np st  crc fl ex ne err cmd
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd3, 3, -1, 1, 0, 0, 0, 3'd0, 1);
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd3, 3, -1, 1, 1, 0, 0, 3'd4, 1);
      run_frame(8'h55, 8'h01, 8'h02, 16'h0002, 16'd0, 0, -1, 1, 0, 0, 0, 3'd0, 1);
      run_frame(8'h56, 8'h01, 8'h81, 16'h0001, 16'd3, 0, -1, 0, 0, 0, 0, 3'd1, 0);
      run_frame(8'h55, 8'h02, 8'h81, 16'h0001, 16'd3, 0, -1, 0, 0, 0, 0, 3'd2, 0);
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd9, 0, -1, 0, 0, 0, 0, 3'd3, 0);
      run_frame(8'h55, 8'h01, 8'h83, 16'h0005, 16'd8, 8, -1, 1, 0, 0, 0, 3'd0, 1);
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd3, 2, -1, 0, 0, 0, 0, 3'd5, 1);
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd3, 3, -1, 1, 0, 1, 0, 3'd6, 1);
      run_frame(8'h55, 8'h01, 8'h81, 16'h0001, 16'd3, 1, -1, 0, 0, 0, 1, 3'd5, 1);
      run_frame(8'h55, 8'h01, 8'h84, 16'h0007, 16'd3, 3, -1, 1, 0, 0, 0, 3'd0, 1);
      run_frame(8'h55, 8'h01, 8'h85, 16'h1234, 16'd3, 3, 1, 1, 0, 0, 0, 3'd0, 1);

      // Reset mid-payload: outputs clear, error count restarts, no verdict.
      strobe_start();
      exp_cmd_q.push_back({8'h81, 16'h0009, 16'd3});
      tx(8'h55, 0); tx(8'hAA, 0); tx(8'h01, 0); tx(8'h81, 0);
      tx(8'h00, 0); tx(8'h09, 0); tx(8'h00, 0); tx(8'h03, 0);
      exp_pay_q.push_back({8'h10, 1'b0});
      tx(8'h10, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("midreset");
      tick();
      rst_n = 1'b1;
      exp_cnt = 0;
      repeat (2) tick();
      run_frame(8'h55, 8'h01, 8'h86, 16'h0003, 16'd3, 3, -1, 1, 0, 0, 0, 3'd0, 1);

      repeat (5) tick();
      check("cmd_queue_left", 40'(exp_cmd_q.size()), 40'd0);
      check("pay_queue_left", 40'(exp_pay_q.size()), 40'd0);
      check("done_queue_left", 40'(exp_done_q.size()), 40'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwu_frame_rx.md
Name: fwu_frame_rx

Overview:
- Receive-side framer for the firmware-update link. Consumes bytes from the SLIP decoder, delimited by start/end strobes.
- Parses and checks the frame: 55 AA 01, type[7:0], seq[15:8], seq[7:0], len[15:8], len[7:0], payload, CRC32 big-endian.
- Streams the payload to the command handler and reports a per-frame pass/fail verdict.
- Mirror of the frame transmitter; it shares the crc32_ieee instance style.

Parameters:
MAX_PAYLOAD, `FWU_MAX_PAYLOAD, largest legal len field; larger len is rejected.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
slip_start  in  1  one-cycle pulse, frame begins; carries no data
slip_end  in  1  one-cycle pulse after the last frame byte; carries no data
slip_data  in  8  decoded byte
slip_valid  in  1  slip_data valid
slip_ready  out  1  byte accepted when slip_valid && slip_ready
cmd_valid  out  1  one-cycle pulse, header accepted
cmd_type  out  8  latched type
cmd_seq  out  16  latched seq
cmd_len  out  16  latched len
pay_data  out  8  payload byte
pay_valid  out  1  payload byte valid
pay_ready  in  1  downstream accepts payload
pay_last  out  1  with pay_valid, final payload byte
frm_done  out  1  one-cycle pulse, frame verdict available
frm_err  out  3  0 OK, 1 MAGIC, 2 VER, 3 LEN, 4 CRC, 5 SHORT, 6 LONG; held until next frm_done
err_cnt  out  16  count of frm_done with frm_err != 0; saturates at FFFF

Behaviour:
- Reset values: all outputs 0; cmd_* 0; state IDLE; err_cnt 0.
- Internal crc32_ieee (init/en/data/crc):
  - Init on slip_start.
  - en on every accepted header or payload byte.
  - Computed value is ~crc, available one cycle after the last en.
- States: IDLE, HDR, PAY, CRC, WAIT_END, DROP.
- slip_start in any state: idx=0, pay count=0, CRC init, go to HDR.
  - If the previous state was HDR/PAY/CRC/WAIT_END/DROP (verdict not yet given), emit frm_done with frm_err=5 (SHORT) on the same cycle before restarting.
- IDLE:
  - Accepts and discards bytes.
  - Ignores slip_end.
- HDR: accept 8 bytes, idx 0..7.
  - Byte 0 != 55 or byte 1 != AA: latch err 1, go to DROP.
  - Byte 2 != 01: latch err 2, go to DROP.
  - Bytes 3..7: latch type/seq/len.
  - On byte 7 with len > MAX_PAYLOAD: err 3, go to DROP, no cmd_valid.
  - On byte 7 otherwise: cmd_valid pulses on the next cycle with cmd_* stable; next state is PAY if len != 0, else CRC.
- PAY:
  - slip_ready = pay_ready; elsewhere slip_ready = 1.
  - pay_valid = slip_valid; pay_data = slip_data (combinational pass-through).
  - pay_last = (count == len-1).
  - Each transfer increments count; on the last byte go to CRC with idx=0.
- CRC:
  - Shift 4 bytes MSB-first into rx_crc.
  - After the 4th byte go to WAIT_END.
- WAIT_END:
  - slip_end: frm_done, frm_err = (rx_crc == ~crc) ? 0 : 4, go to IDLE.
  - Any accepted byte: err 6, go to DROP.
- DROP:
  - Accepts and discards bytes.
  - slip_end: frm_done with the latched error, go to IDLE.
- slip_end in HDR/PAY/CRC: frm_done err 5, go to IDLE.
- frm_done is a registered pulse, one cycle after the slip_end/slip_start that caused it.
- err_cnt increments in the same cycle frm_done asserts.
- Payload is not buffered: downstream must discard on frm_err != 0.
- Reset mid-frame: immediate return to IDLE with no frm_done.
- Bytes and strobes never coincide; slip_start has priority if they do.

Test Plan:
- Good frame, type 81, seq 0001, len 3, payload 10 20 30, correct CRC (bench model) -> cmd_valid once with 81/0001/0003; pay 10,20,30 with pay_last on 30; frm_done frm_err=0; err_cnt=0.
- Same frame with CRC LSB flipped -> payload still streamed, frm_err=4, err_cnt=1; len=0 frame with valid CRC -> no pay_valid, frm_err=0.
- First byte 56, and separately version byte 02 -> no cmd_valid, no pay_valid, frm_err=1 and 2 respectively at slip_end.
- len = MAX_PAYLOAD+1 -> frm_err=3, no cmd_valid; len = MAX_PAYLOAD -> accepted.
- slip_end after 2 payload bytes of len 3 -> frm_err=5; extra byte after CRC -> frm_err=6; slip_start mid-payload followed by a good frame -> err 5 verdict then frm_err=0.
- pay_ready held low 5 cycles mid-payload -> slip_ready low, no byte lost or duplicated, CRC still OK; rst_n asserted mid-frame -> all outputs 0, next good frame passes.
